// File: rtl/elastic_pipe_reg_pkg.sv
// Shared constants and types for the elastic pipeline boundary register:
// bubble encoding, WEN polarity and the occupancy state encoding.
package elastic_pipe_reg_pkg;

    // addi x0,x0,0 -- the canonical RISC-V no-op used as the bubble payload
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // WEN is active-low: 0 lets the stage move, 1 freezes it
    localparam logic WEN_WRITE  = 1'b0;
    localparam logic WEN_FREEZE = 1'b1;

    // Occupancy of the boundary: nothing, main only, main plus skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    // True when the write-enable level requests a freeze
    function automatic logic stage_frozen(input logic wen);
        return (wen == WEN_FREEZE);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear first, otherwise step unless already at the ceiling
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready register for one pipeline boundary. With SKID=1 a
// second entry absorbs the in-flight word so ready_out depends only on
// registered state; with SKID=0 it is a single register whose ready_out
// looks through to ready_in. Supports freeze (WEN), flush (squash) and
// keeps saturating stall/squash statistics.
module elastic_pipe_reg
    import elastic_pipe_reg_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_INSN),
    parameter int               CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_out,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ready_in,
    input  logic             WEN,
    input  logic             squash,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;

    logic frozen;
    logic holding;
    logic can_take;
    logic accept;
    logic deliver;
    logic stall_inc;
    logic squash_inc;

    assign frozen  = stage_frozen(WEN);
    assign holding = (state_q != ST_EMPTY);

    // Upstream handshake. Reset and squash both close the door so nothing
    // slips in on a cycle whose contents are about to be thrown away.
    generate
        if (SKID != 0) begin : g_skid
            assign can_take = (state_q != ST_TWO);
        end else begin : g_single
            assign can_take = !holding || ready_in;
        end
    endgenerate

    assign ready_out = can_take && (WEN == WEN_WRITE) && !squash && !RST;
    assign accept    = valid_in && ready_out;

    // A frozen or squashed stage never hands its word downstream
    assign deliver   = holding && ready_in && !frozen && !squash;

    assign valid_out = holding;
    assign data_out  = holding ? main_q : NOP_VALUE;

    // Occupancy and payload movement; squash outranks freeze
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (squash) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else if (frozen) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = data_in;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (deliver && accept) begin
                        main_d = data_in;
                    end else if (deliver) begin
                        main_d  = NOP_VALUE;
                        state_d = ST_EMPTY;
                    end else if (accept && (SKID != 0)) begin
                        skid_d  = data_in;
                        state_d = ST_TWO;
                    end
                end
                ST_TWO: begin
                    // ready_out is low here, so only the drain case exists
                    if (deliver) begin
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy register; reset drops anything in flight immediately
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers need no reset: data_out is masked to the bubble
    // whenever the occupancy says the stage is empty
    always_ff @(posedge CLK) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign stall_inc  = (valid_in && !ready_out) || (valid_out && !ready_in);
    assign squash_inc = squash && holding;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .inc_i (stall_inc),
        .clr_i (clr_cnt),
        .cnt_o (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_squash_cnt (
        .clk_i (CLK),
        .rst_i (RST),
        .inc_i (squash_inc),
        .clr_i (clr_cnt),
        .cnt_o (squash_cnt)
    );

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Testbench for elastic_pipe_reg: directed scenarios on a skid instance
// with a scoreboard queue checked by a negedge monitor, plus a small
// single-register instance with 2-bit counters for saturation.
module tb_elastic_pipe_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in = 1'b1;
    logic        wen      = 1'b0;
    logic        squash   = 1'b0;
    logic        clr_cnt  = 1'b0;
    logic [31:0] data_in  = 32'h0;
    logic        ready_out;
    logic        valid_out;
    logic [31:0] data_out;
    logic [15:0] stall_cnt;
    logic [15:0] squash_cnt;

    logic        s_valid_in = 1'b0;
    logic        s_ready_in = 1'b0;
    logic        s_wen      = 1'b0;
    logic        s_squash   = 1'b0;
    logic        s_clr      = 1'b0;
    logic [7:0]  s_data_in  = 8'h0;
    logic        s_ready_out;
    logic        s_valid_out;
    logic [7:0]  s_data_out;
    logic [1:0]  s_stall_cnt;
    logic [1:0]  s_squash_cnt;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    elastic_pipe_reg #(
        .WIDTH (32), .SKID (1), .CNT_W (16)
    ) u_dut (
        .CLK (clk), .RST (rst),
        .valid_in (valid_in), .data_in (data_in), .ready_out (ready_out),
        .valid_out (valid_out), .data_out (data_out), .ready_in (ready_in),
        .WEN (wen), .squash (squash), .clr_cnt (clr_cnt),
        .stall_cnt (stall_cnt), .squash_cnt (squash_cnt)
    );

    elastic_pipe_reg #(
        .WIDTH (8), .SKID (0), .CNT_W (2)
    ) u_sat (
        .CLK (clk), .RST (rst),
        .valid_in (s_valid_in), .data_in (s_data_in), .ready_out (s_ready_out),
        .valid_out (s_valid_out), .data_out (s_data_out), .ready_in (s_ready_in),
        .WEN (s_wen), .squash (s_squash), .clr_cnt (s_clr),
        .stall_cnt (s_stall_cnt), .squash_cnt (s_squash_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: idle output must be the bubble; each delivery pops the queue
    always @(negedge clk) begin
        if (!valid_out) check("nop_when_idle", data_out, NOP);
        if (!rst && valid_out && ready_in && !wen && !squash) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_delivery: got 0x%08h expected none", data_out);
            end else begin
                check("delivery_order", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset values
        #1 rst = 1'b1;
        #1;
        check("rst_valid_out",  32'(valid_out),  32'd0);
        check("rst_data_out",   data_out,        NOP);
        check("rst_ready_out",  32'(ready_out),  32'd0);
        check("rst_stall_cnt",  32'(stall_cnt),  32'd0);
        check("rst_squash_cnt", 32'(squash_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1 check("ready_after_rst", 32'(ready_out), 32'd1);

        // Streaming
        ready_in = 1'b1; valid_in = 1'b1; data_in = 32'h11;
        exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33);
        tick();
        check("stream_latency_valid", 32'(valid_out), 32'd1);
        check("stream_first_data",    data_out,       32'h11);
        data_in = 32'h22; tick();
        data_in = 32'h33; tick();
        valid_in = 1'b0; tick();
        check("stream_stall_cnt", 32'(stall_cnt),    32'd0);
        check("stream_drained",   32'(valid_out),    32'd0);
        check("stream_queue",     32'(exp_q.size()), 32'd0);

        // Backpressure
        ready_in = 1'b0; valid_in = 1'b1; data_in = 32'hA;
        exp_q.push_back(32'hA); exp_q.push_back(32'hB); exp_q.push_back(32'hC);
        tick();
        data_in = 32'hB; tick();
        check("bp_ready_out_two", 32'(ready_out), 32'd0);
        check("bp_head",          data_out,       32'hA);
        data_in = 32'hC; tick();
        check("bp_c_held", 32'(ready_out), 32'd0);
        ready_in = 1'b1; tick();
        tick();
        valid_in = 1'b0; tick();
        check("bp_stall_cnt", 32'(stall_cnt),    32'd3);
        check("bp_drained",   32'(valid_out),    32'd0);
        check("bp_queue",     32'(exp_q.size()), 32'd0);
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        check("clr_stall_cnt", 32'(stall_cnt), 32'd0);

        // Squash from TWO with a concurrent offer
        ready_in = 1'b0; valid_in = 1'b1; data_in = 32'h61;
        exp_q.push_back(32'h61); exp_q.push_back(32'h62);
        tick();
        data_in = 32'h62; tick();
        check("sq_pre_two", 32'(ready_out), 32'd0);
        data_in = 32'h55; squash = 1'b1; tick();
        squash = 1'b0; valid_in = 1'b0; exp_q.delete();
        check("sq_valid_out", 32'(valid_out),  32'd0);
        check("sq_data_out",  data_out,        NOP);
        check("sq_cnt",       32'(squash_cnt), 32'd1);
        ready_in = 1'b1; tick(); tick();

        // Squash beats freeze; squash of an empty stage is not counted
        ready_in = 1'b0; valid_in = 1'b1; data_in = 32'h70; exp_q.push_back(32'h70);
        tick();
        valid_in = 1'b0; wen = 1'b1; squash = 1'b1; tick();
        wen = 1'b0; squash = 1'b0; exp_q.delete();
        check("sq_over_wen_valid", 32'(valid_out),  32'd0);
        check("sq_over_wen_cnt",   32'(squash_cnt), 32'd2);
        squash = 1'b1; tick(); squash = 1'b0;
        check("sq_empty_no_count", 32'(squash_cnt), 32'd2);

        // Freeze
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        ready_in = 1'b1; valid_in = 1'b1; data_in = 32'h77; exp_q.push_back(32'h77);
        tick();
        valid_in = 1'b0; wen = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_data",  data_out,       32'h77);
            check("frz_valid", 32'(valid_out), 32'd1);
        end
        check("frz_stall_cnt", 32'(stall_cnt), 32'd0);
        wen = 1'b0; tick();
        check("frz_delivered_once", 32'(valid_out),    32'd0);
        check("frz_queue",          32'(exp_q.size()), 32'd0);
        tick();

        // Asynchronous reset in TWO
        ready_in = 1'b0; valid_in = 1'b1; data_in = 32'h81;
        exp_q.push_back(32'h81); exp_q.push_back(32'h82);
        tick();
        data_in = 32'h82; tick();
        valid_in = 1'b0;
        check("rst_pre_stall", 32'(stall_cnt), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid_out",  32'(valid_out),  32'd0);
        check("arst_data_out",   data_out,        NOP);
        check("arst_stall_cnt",  32'(stall_cnt),  32'd0);
        check("arst_ready_out",  32'(ready_out),  32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        ready_in = 1'b1; valid_in = 1'b1; data_in = 32'h91; exp_q.push_back(32'h91);
        tick();
        check("post_rst_accept", 32'(valid_out), 32'd1);
        check("post_rst_data",   data_out,       32'h91);
        valid_in = 1'b0; tick();

        // Saturation on the single-register instance with 2-bit counters
        s_valid_in = 1'b1; s_data_in = 8'h5A; s_ready_in = 1'b0;
        tick();
        check("single_ready_blocked", 32'(s_ready_out), 32'd0);
        check("single_data",          32'(s_data_out),  32'h5A);
        repeat (5) tick();
        check("sat_stall_cnt", 32'(s_stall_cnt), 32'd3);
        s_clr = 1'b1; tick(); s_clr = 1'b0;
        check("sat_clr_cnt", 32'(s_stall_cnt), 32'd0);
        s_ready_in = 1'b1;
        #1 check("single_ready_comb", 32'(s_ready_out), 32'd1);
        tick();
        s_valid_in = 1'b0; tick();
        check("single_drained",   32'(s_valid_out),  32'd0);
        check("single_nop_trunc", 32'(s_data_out),   32'h13);
        check("single_squash_cnt", 32'(s_squash_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_reg.md
ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter SKID, default 1, 1 = two-entry skid buffer, 0 = single register.
REQ-003 SHALL have parameter NOP_VALUE, default 32'h00000013 zero-extended/truncated to WIDTH, bubble payload.
REQ-004 SHALL have parameter CNT_W, default 16, width of the statistics counters.
REQ-005 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port valid_in  input  1  upstream payload valid.
REQ-008 SHALL have port data_in  input  WIDTH  upstream payload.
REQ-009 SHALL have port ready_out  output  1  stage can accept this cycle.
REQ-010 SHALL have port valid_out  output  1  downstream payload valid.
REQ-011 SHALL have port data_out  output  WIDTH  downstream payload.
REQ-012 SHALL have port ready_in  input  1  downstream accepts this cycle.
REQ-013 SHALL have port WEN  input  1  active-low write enable; 1 = freeze stage.
REQ-014 SHALL have port squash  input  1  flush all held entries to bubbles.
REQ-015 SHALL have port clr_cnt  input  1  synchronous clear of both counters.
REQ-016 SHALL have ports stall_cnt, squash_cnt  output  CNT_W  saturating statistics.

Function
REQ-017 SHALL define acceptance as valid_in & ready_out, and delivery as valid_out & ready_in.
REQ-018 SHALL, with SKID=1, implement states EMPTY, ONE (main full), TWO (main and skid full).
REQ-019 SHALL transition EMPTY->ONE on acceptance; ONE->EMPTY on delivery without acceptance; ONE->TWO on acceptance without delivery; ONE->ONE on both or neither.
REQ-020 SHALL transition TWO->ONE on delivery, with the skid entry moving into main the same edge.
REQ-021 SHALL, with SKID=1, drive ready_out = (state != TWO) & !WEN & !squash, registered-state only, with no combinational path from ready_in.
REQ-022 SHALL, with SKID=0, drive ready_out = (!valid_out | ready_in) & !WEN & !squash.
REQ-023 SHALL present data in strict FIFO order, with latency of exactly one cycle from acceptance to valid_out when the stage was EMPTY.
REQ-024 SHALL drive data_out = NOP_VALUE whenever valid_out = 0.
REQ-025 SHALL, while WEN=1, hold state, payloads and valid_out unchanged, and block delivery by treating it as not occurring.
REQ-026 SHALL, on squash=1 at an edge, go to EMPTY, discard any same-cycle acceptance and delivery, and set held payloads to NOP_VALUE.
REQ-027 SHALL give squash priority over WEN when both are asserted.
REQ-028 SHALL increment stall_cnt on each edge where valid_in=1 and ready_out=0, or where valid_out=1 and ready_in=0.
REQ-029 SHALL increment squash_cnt on each edge with squash=1 and at least one entry valid.
REQ-030 SHALL saturate both counters at 2^CNT_W-1 without wrap.
REQ-031 SHALL give clr_cnt priority over increment, with the counters reading 0 after the edge.

Reset
REQ-032 SHALL, on RST=1, asynchronously force state EMPTY, valid_out=0, data_out=NOP_VALUE and both counters to 0.
REQ-033 SHALL drop in-flight entries on RST asserted mid-transfer, and ready_out SHALL be 0 while RST=1.
REQ-034 SHALL accept on the first rising CLK after RST deasserts.

Structure
REQ-035 SHALL take the NOP encoding (addi x0,x0,0) and the WEN polarity constants from the shared CPU defines package.
REQ-036 SHALL contain one natural sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.
REQ-037 SHALL replace the per-stage register blocks, with one instance per pipeline boundary and payload packed by the instantiating level.

Verification
REQ-038 SHALL verify the streaming scenario: SKID=1, ready_in=1, send 0x11,0x22,0x33 back-to-back -> valid_out each cycle with one-cycle latency, order 0x11,0x22,0x33, stall_cnt=0.
REQ-039 SHALL verify the backpressure scenario: ready_in=0, send 0xA,0xB,0xC -> state TWO after 0xB, ready_out=0, 0xC held upstream; on release, output 0xA,0xB,0xC in order.
REQ-040 SHALL verify the squash scenario: state TWO, squash=1 with valid_in=1 (0x55) -> next cycle valid_out=0, data_out=0x00000013, 0x55 not delivered, squash_cnt=1.
REQ-041 SHALL verify the freeze scenario: ONE holding 0x77, WEN=1 for 3 cycles with ready_in=1 -> data_out stays 0x77, valid_out=1, stall_cnt=0; after WEN=0, 0x77 is delivered once.
REQ-042 SHALL verify the saturation scenario: CNT_W=2, 5 stalled cycles -> stall_cnt=3; clr_cnt with a concurrent stall -> 0.
REQ-043 SHALL verify the reset scenario: RST asserted mid-cycle in TWO -> immediate valid_out=0, data_out=NOP_VALUE, counters 0, without waiting for CLK.
